// File: rtl/mod_exp_engine.sv
// Word-serial Montgomery modular exponentiation: result = base^exp mod N, MSB-first square-and-multiply.
// Optional MODEXP_SKIP_LZ_EN: skip the exponent's leading zeros instead of the constant-time full scan.
module mod_exp_engine #(
  parameter int WIDTH     = 256,
  parameter int WORD_W    = 32,
  parameter int EXP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exp,
  input  logic [WIDTH-1:0]     modulus,
  input  logic [WIDTH-1:0]     r2,
  input  logic [WORD_W-1:0]    mp,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result
);

  localparam int NW = WIDTH / WORD_W;
  localparam int CW = $clog2(NW + 1);
  localparam int IW = $clog2(EXP_WIDTH);
  localparam int TT = WIDTH + 2;           // running t between digit steps (< 2N)
  localparam int TW = WIDTH + WORD_W + 2;  // t + a_i*b + q*N before the shift
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PRE_X, S_PRE_A, S_SQR, S_MUL, S_POST, S_FIN
  } state_t;

  state_t                 r_state;
  logic [WIDTH-1:0]       r_base, r_mod, r_r2, r_xm, r_acc;
  logic [EXP_WIDTH-1:0]   r_exp;
  logic [WORD_W-1:0]      r_mp;
  logic [TT-1:0]          r_t;
  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_idx;

  logic [WIDTH-1:0]       w_a, w_b, w_mm;
  logic [WORD_W-1:0]      w_digit, w_q;
  logic [TW-1:0]          w_t1;
  logic [TT-1:0]          w_t_next;
  logic                   w_ge, w_last_mm;

  always_comb begin
    w_a = '0;
    w_b = '0;
    case (r_state)
      S_PRE_X: begin w_a = r_base; w_b = r_r2;  end
      S_PRE_A: begin w_a = ONE;    w_b = r_r2;  end
      S_SQR:   begin w_a = r_acc;  w_b = r_acc; end
      S_MUL:   begin w_a = r_acc;  w_b = r_xm;  end
      S_POST:  begin w_a = r_acc;  w_b = ONE;   end
      default: begin w_a = '0;     w_b = '0;    end
    endcase
  end

  // One Montgomery digit step: add a_i*b, pick q to clear the low digit, shift it out.
  assign w_digit   = WORD_W'(w_a >> (32'(r_cnt) * WORD_W));
  assign w_t1      = TW'(r_t) + TW'(w_digit) * TW'(w_b);
  assign w_q       = w_t1[WORD_W-1:0] * r_mp;
  assign w_t_next  = TT'((w_t1 + TW'(w_q) * TW'(r_mod)) >> WORD_W);
  assign w_ge      = (r_t >= TT'(r_mod));
  assign w_mm      = w_ge ? WIDTH'(r_t - TT'(r_mod)) : r_t[WIDTH-1:0];
  assign w_last_mm = (r_cnt == CW'(NW));

`ifdef MODEXP_SKIP_LZ_EN
  logic [IW-1:0] w_msb;
  always_comb begin
    w_msb = '0;
    for (int i = 0; i < EXP_WIDTH; i++) begin
      if (r_exp[i]) w_msb = IW'(i);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      r_cnt   <= '0;
      r_t     <= '0;
      r_idx   <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base  <= base;
            r_exp   <= exp;
            r_mod   <= modulus;
            r_r2    <= r2;
            r_mp    <= mp;
            busy    <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_cnt   <= '0;
          r_t     <= '0;
`ifdef MODEXP_SKIP_LZ_EN
          r_idx   <= w_msb;
`else
          r_idx   <= IW'(EXP_WIDTH - 1);
`endif
          r_state <= S_PRE_X;
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          if (!w_last_mm) begin
            r_t   <= w_t_next;
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_t   <= '0;
            r_cnt <= '0;
            case (r_state)
              S_PRE_X: begin
                r_xm    <= w_mm;
                r_state <= S_PRE_A;
              end
              S_PRE_A: begin
                r_acc   <= w_mm;
`ifdef MODEXP_SKIP_LZ_EN
                r_state <= (r_exp == '0) ? S_POST : S_SQR;
`else
                r_state <= S_SQR;
`endif
              end
              S_SQR: begin
                r_acc <= w_mm;
                if (r_exp[r_idx]) begin
                  r_state <= S_MUL;
                end else if (r_idx == '0) begin
                  r_state <= S_POST;
                end else begin
                  r_idx   <= r_idx - IW'(1);
                  r_state <= S_SQR;
                end
              end
              S_MUL: begin
                r_acc <= w_mm;
                if (r_idx == '0) begin
                  r_state <= S_POST;
                end else begin
                  r_idx   <= r_idx - IW'(1);
                  r_state <= S_SQR;
                end
              end
              S_POST: begin
                result  <= w_mm;
                done    <= 1'b1;
                busy    <= 1'b0;
                r_state <= S_FIN;
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_engine.sv
// Scoreboard bench for mod_exp_engine: a 16-bit instance for the directed vectors and a default 256-bit instance.
module tb_mod_exp_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        s_start = 1'b0;
  logic [15:0] s_base = '0, s_exp = '0, s_mod = '0, s_r2 = '0;
  logic [7:0]  s_mp = '0;
  logic        s_busy, s_done;
  logic [15:0] s_result;

  logic         l_start = 1'b0;
  logic [255:0] l_base = '0, l_mod = '0, l_r2 = '0;
  logic [31:0]  l_exp = '0;
  logic [31:0]  l_mp = '0;
  logic         l_busy, l_done;
  logic [255:0] l_result;

  mod_exp_engine #(.WIDTH(16), .WORD_W(8), .EXP_WIDTH(16)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .base(s_base), .exp(s_exp),
    .modulus(s_mod), .r2(s_r2), .mp(s_mp),
    .busy(s_busy), .done(s_done), .result(s_result)
  );

  mod_exp_engine u_large (
    .clk(clk), .rst(rst), .start(l_start), .base(l_base), .exp(l_exp),
    .modulus(l_mod), .r2(l_r2), .mp(l_mp),
    .busy(l_busy), .done(l_done), .result(l_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard queues: expected result, expected done cycle, start edge, name.
  logic [255:0] q_s_res[$];
  int           q_s_cyc[$], q_s_st[$];
  string        q_s_nm[$];
  logic [255:0] q_l_res[$];
  int           q_l_cyc[$], q_l_st[$];
  string        q_l_nm[$];
  int           q_rchk[$];

  int           s_gap = 0, l_gap = 0;
  logic [255:0] m_res;
  int           m_cyc, m_st;
  string        m_nm;

  always @(negedge clk) begin
    while (q_rchk.size() != 0 && q_rchk[0] <= cyc) begin
      m_cyc = q_rchk.pop_front();
      checks++;
      if (s_busy !== 1'b0 || s_done !== 1'b0 || s_result !== 16'h0) begin
        errors++;
        $display("FAIL reset_state_small cyc=%0d got busy=%b done=%b result=%h want 0/0/0000",
                 cyc, s_busy, s_done, s_result);
      end
      checks++;
      if (l_busy !== 1'b0 || l_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_state_large cyc=%0d got busy=%b done=%b want 0/0", cyc, l_busy, l_done);
      end
    end

    if (q_s_res.size() != 0 && cyc >= q_s_st[0] && s_done !== 1'b1 && s_busy !== 1'b1) s_gap++;
    if (s_done === 1'b1) begin
      checks++;
      if (q_s_res.size() == 0) begin
        errors++;
        $display("FAIL small_unexpected_done cyc=%0d result=%h want no done", cyc, s_result);
      end else begin
        m_res = q_s_res.pop_front(); m_cyc = q_s_cyc.pop_front();
        m_st = q_s_st.pop_front();   m_nm = q_s_nm.pop_front();
        if (s_result !== m_res[15:0]) begin
          errors++;
          $display("FAIL %s result got %h want %h", m_nm, s_result, m_res[15:0]);
        end
        checks++;
        if (cyc != m_cyc) begin
          errors++;
          $display("FAIL %s latency got %0d want %0d", m_nm, cyc - m_st, m_cyc - m_st);
        end
        checks++;
        if (s_gap != 0) begin
          errors++;
          $display("FAIL %s busy_low_cycles got %0d want 0", m_nm, s_gap);
        end
        $display("txn %s result=%h latency=%0d", m_nm, s_result, cyc - m_st);
      end
      s_gap = 0;
    end else if (q_s_res.size() != 0 && cyc > q_s_cyc[0] + 8) begin
      checks++; errors++;
      $display("FAIL %s missing_done got none by cyc %0d want done at %0d", q_s_nm[0], cyc, q_s_cyc[0]);
      m_res = q_s_res.pop_front(); m_cyc = q_s_cyc.pop_front();
      m_st = q_s_st.pop_front();   m_nm = q_s_nm.pop_front();
      s_gap = 0;
    end

    if (q_l_res.size() != 0 && cyc >= q_l_st[0] && l_done !== 1'b1 && l_busy !== 1'b1) l_gap++;
    if (l_done === 1'b1) begin
      checks++;
      if (q_l_res.size() == 0) begin
        errors++;
        $display("FAIL large_unexpected_done cyc=%0d result=%h want no done", cyc, l_result);
      end else begin
        m_res = q_l_res.pop_front(); m_cyc = q_l_cyc.pop_front();
        m_st = q_l_st.pop_front();   m_nm = q_l_nm.pop_front();
        if (l_result !== m_res) begin
          errors++;
          $display("FAIL %s result got %h want %h", m_nm, l_result, m_res);
        end
        checks++;
        if (cyc != m_cyc) begin
          errors++;
          $display("FAIL %s latency got %0d want %0d", m_nm, cyc - m_st, m_cyc - m_st);
        end
        checks++;
        if (l_gap != 0) begin
          errors++;
          $display("FAIL %s busy_low_cycles got %0d want 0", m_nm, l_gap);
        end
        $display("txn %s result=%h latency=%0d", m_nm, l_result, cyc - m_st);
      end
      l_gap = 0;
    end else if (q_l_res.size() != 0 && cyc > q_l_cyc[0] + 8) begin
      checks++; errors++;
      $display("FAIL %s missing_done got none by cyc %0d want done at %0d", q_l_nm[0], cyc, q_l_cyc[0]);
      m_res = q_l_res.pop_front(); m_cyc = q_l_cyc.pop_front();
      m_st = q_l_st.pop_front();   m_nm = q_l_nm.pop_front();
      l_gap = 0;
    end
  end

  // Drives a request at the coming negedge; 'track' pushes the expected response.
  task automatic issue_s(input logic [15:0] b, input logic [15:0] e, input logic [15:0] n,
                         input logic [15:0] r, input logic [7:0] m, input logic [15:0] want,
                         input int lat, input string nm, input bit track);
    @(negedge clk);
    s_base = b; s_exp = e; s_mod = n; s_r2 = r; s_mp = m; s_start = 1'b1;
    if (track) begin
      q_s_res.push_back({240'h0, want});
      q_s_cyc.push_back(cyc + 1 + lat);
      q_s_st.push_back(cyc + 1);
      q_s_nm.push_back(nm);
    end
    @(negedge clk);
    s_start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (q_s_res.size() == 0 && q_l_res.size() == 0) break;
      @(negedge clk);
    end
    if (q_s_res.size() != 0 || q_l_res.size() != 0) begin
      $display("FAIL drain_timeout pending small=%0d large=%0d want 0", q_s_res.size(), q_l_res.size());
      $fatal(1, "scoreboard did not drain");
    end
    repeat (4) @(negedge clk);
  endtask

  // Directed vectors: base, exp, N, r2, mp, expected, latency (full scan / leading-zero skip).
  localparam int NV = 7;
  logic [15:0] v_b[NV]   = '{16'd7,   16'd3,   16'd2,   16'd9,   16'd0,   16'd2,   16'd252};
  logic [15:0] v_e[NV]   = '{16'd3,   16'd5,   16'd8,   16'd0,   16'd4,   16'd10,  16'd7};
  logic [15:0] v_n[NV]   = '{16'hFD,  16'hFF,  16'hFF,  16'hFD,  16'hFD,  16'hFD,  16'hFD};
  logic [15:0] v_r[NV]   = '{16'h51,  16'h01,  16'h01,  16'h51,  16'h51,  16'h51,  16'h51};
  logic [7:0]  v_m[NV]   = '{8'hAB,   8'h01,   8'h01,   8'hAB,   8'hAB,   8'hAB,   8'hAB};
  logic [15:0] v_x[NV]   = '{16'h5A,  16'hF3,  16'h01,  16'h01,  16'h00,  16'h0C,  16'hFC};
  int          v_ln[NV]  = '{64, 64, 61, 58, 61, 64, 67};
  int          v_lm[NV]  = '{22, 25, 25, 10, 22, 28, 28};

  function automatic int pick(input int full_lat, input int skip_lat);
`ifdef MODEXP_SKIP_LZ_EN
    return skip_lat;
`else
    return full_lat;
`endif
  endfunction

  logic [255:0] big_want;
  int           wait_i;

  initial begin
    repeat (3) @(negedge clk);
    q_rchk.push_back(cyc + 1);
    @(negedge clk);
    rst = 1'b0;

    // start in the same cycle as rst: rst wins, engine stays idle
    s_base = 16'd7; s_exp = 16'd3; s_mod = 16'hFD; s_r2 = 16'h51; s_mp = 8'hAB;
    rst = 1'b1; s_start = 1'b1;
    q_rchk.push_back(cyc + 1);
    @(negedge clk);
    rst = 1'b0; s_start = 1'b0;
    q_rchk.push_back(cyc + 1);
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      issue_s(v_b[i], v_e[i], v_n[i], v_r[i], v_m[i], v_x[i], pick(v_ln[i], v_lm[i]),
              $sformatf("vec%0d_%0d^%0d", i, v_b[i], v_e[i]), 1'b1);
      drain();
    end

    // second start and input changes while busy must not disturb the first request
    issue_s(16'd7, 16'd3, 16'hFD, 16'h51, 8'hAB, 16'h5A, pick(64, 22), "busy_restart", 1'b1);
    repeat (8) @(negedge clk);
    issue_s(16'd3, 16'd5, 16'hFF, 16'h01, 8'h01, 16'hF3, 0, "ignored", 1'b0);
    s_base = 16'd11; s_exp = 16'hFFFF; s_mod = 16'hFF;
    drain();
    repeat (80) @(negedge clk);

    // start during FIN is ignored; the following cycle accepts a new one
    issue_s(16'd2, 16'd10, 16'hFD, 16'h51, 8'hAB, 16'h0C, pick(64, 28), "pre_fin", 1'b1);
    wait_i = 0;
    while (s_done !== 1'b1 && wait_i < 200) begin
      @(negedge clk);
      wait_i++;
    end
    s_base = 16'd9; s_exp = 16'd1; s_start = 1'b1;
    @(negedge clk);
    s_base = 16'd3; s_exp = 16'd5; s_mod = 16'hFF; s_r2 = 16'h01; s_mp = 8'h01;
    q_s_res.push_back({240'h0, 16'hF3});
    q_s_cyc.push_back(cyc + 1 + pick(64, 25));
    q_s_st.push_back(cyc + 1);
    q_s_nm.push_back("after_fin");
    @(negedge clk);
    s_start = 1'b0;
    drain();
    repeat (80) @(negedge clk);

    // reset mid-SQR discards the run; a fresh start then completes normally
    issue_s(16'd7, 16'd3, 16'hFD, 16'h51, 8'hAB, 16'h5A, 0, "aborted", 1'b0);
    repeat (18) @(negedge clk);
    rst = 1'b1;
    q_rchk.push_back(cyc + 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    issue_s(16'd3, 16'd5, 16'hFF, 16'h01, 8'h01, 16'hF3, pick(64, 25), "after_rst", 1'b1);
    drain();
    repeat (80) @(negedge clk);

    // default 256-bit configuration: 2^255 mod (2^256-1)
    big_want = '0;
    big_want[255] = 1'b1;
    @(negedge clk);
    l_base = 256'd2; l_exp = 32'd255; l_mod = '1; l_r2 = 256'd1; l_mp = 32'd1; l_start = 1'b1;
    q_l_res.push_back(big_want);
    q_l_cyc.push_back(cyc + 1 + pick(388, 172));
    q_l_st.push_back(cyc + 1);
    q_l_nm.push_back("large_2^255");
    @(negedge clk);
    l_start = 1'b0;
    drain();
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_exp_engine.md
Name: mod_exp_engine

Overview:
- Parametrised Montgomery modular-exponentiation engine; computes result = base^exp mod N.
- Successor to the fixed 256-bit/32-bit-exponent RSA core, generalised in operand width, digit width and exponent width.
- Adds a start/busy/done handshake, input capture and host-supplied R^2 mod N.
- Sits behind the crypto register block; one operation in flight at a time.

Parameters:
- WIDTH, 256: operand/modulus width in bits; must be a multiple of WORD_W.
- WORD_W, 32: Montgomery digit width (radix 2^WORD_W); also the width of mp.
- EXP_WIDTH, 32: exponent width in bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- base  in  WIDTH  base; must be < N.
- exp  in  EXP_WIDTH  exponent.
- modulus  in  WIDTH  N; must be odd.
- r2  in  WIDTH  R^2 mod N, where R = 2^WIDTH.
- mp  in  WORD_W  -N^-1 mod 2^WORD_W.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when result is valid.
- result  out  WIDTH  base^exp mod N; held until the next done or reset.

Behaviour:
- Reset: on rst=1 at a clk edge, state goes to IDLE and busy=0, done=0, result=0. Reset takes effect in any state, including mid-operation; the in-flight operation is discarded.
- Capture: start=1 in IDLE at edge k captures base, exp, modulus, r2 and mp into internal registers. busy=1 from edge k. Later input changes are ignored until done. start while busy is ignored (no queueing).
- MontMul(a,b) = a*b*R^-1 mod N, computed word-serially over NW = WIDTH/WORD_W digits, one digit per cycle:
  - t = t + a_i*b
  - q = (t[WORD_W-1:0]*mp) mod 2^WORD_W
  - t = (t + q*N) >> WORD_W
  - Then one final cycle: if t >= N, t = t - N.
  - Each MontMul takes NW+1 cycles.
  - Datapath width: t needs WIDTH+WORD_W+1 bits internally; the final t is < N.
- States:
  - IDLE: wait for start.
  - LOAD (1 cycle): zero the digit counter; bit index = EXP_WIDTH-1.
  - PRE_X: xm = MontMul(base, r2).
  - PRE_A: acc = MontMul(1, r2) (= R mod N).
  - SQR: acc = MontMul(acc, acc).
  - MUL: acc = MontMul(acc, xm), entered only if exp[idx]=1.
  - After SQR (or MUL): if idx=0 go to POST, else idx--, go to SQR.
  - POST: result = MontMul(acc, 1).
  - FIN: done=1 for one cycle, busy=0, back to IDLE.
- Exponent scan: left-to-right, MSB first.
- Latency from the start edge to the done-high cycle: 1 + (NW+1)*(3 + S + popcount(exp)), where S = EXP_WIDTH squarings.
- Boundaries:
  - exp=0 gives result 1 (0 if N=1).
  - base=0 with exp>0 gives 0.
  - Even N or out-of-range inputs give an undefined result, but the FSM still terminates with the same latency.
  - start asserted in the same cycle as rst: rst wins.
  - start in the FIN cycle is ignored; a new start is accepted from the next cycle, when the engine is back in IDLE.

Optional Feature:
- Macro: MODEXP_SKIP_LZ_EN.
- Defined: LOAD scans exp for its highest set bit h. The SQR/MUL loop starts at idx=h, with S = h+1. exp=0 skips the loop entirely (S=0): PRE_X, PRE_A, POST, then FIN.
- Undefined: all EXP_WIDTH bits are processed, so latency is independent of the exp leading zeros (constant-time schedule).

Test Plan:
- WIDTH=16, WORD_W=8, EXP_WIDTH=16: N=0x00FD, mp=0xAB, r2=0x0051, base=7, exp=3 -> result=0x005A. done at 64 cycles without the macro, 22 cycles with MODEXP_SKIP_LZ_EN.
- Same config: N=0x00FF, mp=0x01, r2=0x0001. base=3, exp=5 -> 0x00F3. base=2, exp=8 -> 0x0001.
- Same config, N=0x00FD: exp=0, base=9 -> result=1. Latency 1+3*19=58 cycles without the macro, 10 with it. base=0, exp=4 -> 0.
- Default config: N=2^256-1, mp=0x00000001, r2=1, base=2, exp=255 -> result=2^255. busy stays high throughout; exactly one done pulse.
- Assert start again while busy, and change the inputs mid-run -> result unchanged from the first request; no second done.
- Assert rst mid-SQR -> busy=0, done=0, result=0 on the next edge. A fresh start then completes correctly with the nominal latency.
